// File: rtl/rename_pkg.sv
// Shared sizes and types for the rename stage: architectural/physical register
// counts, tag and data widths, and free-list geometry.
package rename_pkg;

  localparam int NUM_ARCH = 32;
  localparam int NUM_PHYS = 64;
  localparam int DATA_W   = 32;
  localparam int TAG_W    = $clog2(NUM_PHYS);
  localparam int AREG_W   = $clog2(NUM_ARCH);

  // The free list only ever holds the non-architectural tags.
  localparam int FL_DEPTH = NUM_PHYS - NUM_ARCH;
  localparam int FL_PTR_W = $clog2(FL_DEPTH);
  localparam int FL_CNT_W = $clog2(FL_DEPTH + 1);

  typedef logic [TAG_W-1:0]  tag_t;
  typedef logic [AREG_W-1:0] areg_t;
  typedef logic [DATA_W-1:0] data_t;

endpackage

// File: rtl/rename_free_list.sv
// Circular FIFO of free physical tags. Reset leaves it full, holding
// NUM_ARCH..NUM_PHYS-1 in order. Pops when empty and pushes when full are dropped.
module rename_free_list
  import rename_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                push_i,
  input  tag_t                push_tag_i,
  input  logic                pop_i,
  output tag_t                head_tag_o,
  output logic [FL_CNT_W-1:0] count_o,
  output logic                empty_o,
  output logic                full_o
);

  tag_t                mem_q [FL_DEPTH];
  logic [FL_PTR_W-1:0] head_q, tail_q;
  logic [FL_CNT_W-1:0] count_q, count_d;
  logic                do_push, do_pop;

  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == FL_CNT_W'(FL_DEPTH));
  assign head_tag_o = mem_q[head_q];
  assign count_o    = count_q;

  assign do_pop  = pop_i  & ~empty_o;
  assign do_push = push_i & ~full_o;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  // Pointers are FL_PTR_W bits wide, so increments wrap modulo FL_DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: this storage is deliberately reset because the initial free tags
      // are architecturally visible; plain data RAMs normally skip reset.
      for (int i = 0; i < FL_DEPTH; i++) mem_q[i] <= tag_t'(NUM_ARCH + i);
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= FL_CNT_W'(FL_DEPTH);
    end else begin
      if (do_push) begin
        mem_q[tail_q] <= push_tag_i;
        tail_q        <= tail_q + 1'b1;
      end
      if (do_pop) head_q <= head_q + 1'b1;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/rename_stage.sv
// Register-rename stage: RAT, physical register file with ready bits, and a
// free list of tags. Define RENAME_BYPASS_EN to forward same-cycle wakeups to sources.
module rename_stage
  import rename_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic        reg_write,
  input  logic [4:0]  architectural_rd,
  input  logic [4:0]  architectural_rs1,
  input  logic [4:0]  architectural_rs2,
  input  logic        wakeup_active,
  input  logic [5:0]  wakeup_tag,
  input  logic [31:0] wakeup_value,
  input  logic        free_valid,
  input  logic [5:0]  free_tag,
  output logic [5:0]  physical_rd,
  output logic [5:0]  old_physical_rd,
  output logic [5:0]  physical_rs1,
  output logic [5:0]  physical_rs2,
  output logic        rs1_ready,
  output logic        rs2_ready,
  output logic [31:0] rs1_value,
  output logic [31:0] rs2_value,
  output logic        rename_stall
);

  tag_t  rat_q   [NUM_ARCH];
  logic  ready_q [NUM_PHYS];
  data_t value_q [NUM_PHYS];

  tag_t                fl_head;
  logic [FL_CNT_W-1:0] fl_count;
  logic                fl_empty, fl_full, fl_push;
  logic                want_alloc, alloc, wake;

  assign want_alloc   = instr_valid & reg_write & (architectural_rd != '0);
  assign alloc        = want_alloc & (fl_count != '0);
  assign rename_stall = want_alloc & fl_empty;
  assign wake         = wakeup_active & (wakeup_tag != '0);
  assign fl_push      = free_valid & (free_tag != '0) & ~fl_full;

  rename_free_list u_free_list (
    .clk        (clk),
    .reset      (reset),
    .push_i     (fl_push),
    .push_tag_i (free_tag),
    .pop_i      (alloc),
    .head_tag_o (fl_head),
    .count_o    (fl_count),
    .empty_o    (fl_empty),
    .full_o     (fl_full)
  );

  // Sources read the pre-update RAT, so rd == rsN still sees the old mapping.
  assign physical_rs1    = rat_q[architectural_rs1];
  assign physical_rs2    = rat_q[architectural_rs2];
  assign physical_rd     = alloc ? fl_head : '0;
  assign old_physical_rd = alloc ? rat_q[architectural_rd] : '0;

  always_comb begin
    rs1_ready = ready_q[physical_rs1];
    rs1_value = value_q[physical_rs1];
    rs2_ready = ready_q[physical_rs2];
    rs2_value = value_q[physical_rs2];
`ifdef RENAME_BYPASS_EN
    if (wake && wakeup_tag == physical_rs1) begin
      rs1_ready = 1'b1;
      rs1_value = wakeup_value;
    end
    if (wake && wakeup_tag == physical_rs2) begin
      rs2_ready = 1'b1;
      rs2_value = wakeup_value;
    end
`endif
  end

  // Tag 0 is never a wakeup target nor allocated, so it stays ready with value 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_ARCH; i++) rat_q[i] <= tag_t'(i);
      for (int i = 0; i < NUM_PHYS; i++) begin
        ready_q[i] <= (i < NUM_ARCH);
        value_q[i] <= '0;
      end
    end else begin
      if (wake) begin
        ready_q[wakeup_tag] <= 1'b1;
        value_q[wakeup_tag] <= wakeup_value;
      end
      // NOTE: the later non-blocking write to the same element wins, which is
      // how allocation overrides a same-cycle wakeup of the head tag.
      if (alloc) begin
        rat_q[architectural_rd] <= fl_head;
        ready_q[fl_head]        <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rename_stage.sv
// Directed self-checking bench for rename_stage; one task per scenario,
// expectations hand-computed from the reset map and FIFO order of free tags.
module tb_rename_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid, reg_write;
  logic [4:0]  architectural_rd, architectural_rs1, architectural_rs2;
  logic        wakeup_active;
  logic [5:0]  wakeup_tag;
  logic [31:0] wakeup_value;
  logic        free_valid;
  logic [5:0]  free_tag;
  logic [5:0]  physical_rd, old_physical_rd, physical_rs1, physical_rs2;
  logic        rs1_ready, rs2_ready;
  logic [31:0] rs1_value, rs2_value;
  logic        rename_stall;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rename_stage dut (
    .clk               (clk),
    .reset             (reset),
    .instr_valid       (instr_valid),
    .reg_write         (reg_write),
    .architectural_rd  (architectural_rd),
    .architectural_rs1 (architectural_rs1),
    .architectural_rs2 (architectural_rs2),
    .wakeup_active     (wakeup_active),
    .wakeup_tag        (wakeup_tag),
    .wakeup_value      (wakeup_value),
    .free_valid        (free_valid),
    .free_tag          (free_tag),
    .physical_rd       (physical_rd),
    .old_physical_rd   (old_physical_rd),
    .physical_rs1      (physical_rs1),
    .physical_rs2      (physical_rs2),
    .rs1_ready         (rs1_ready),
    .rs2_ready         (rs2_ready),
    .rs1_value         (rs1_value),
    .rs2_value         (rs2_value),
    .rename_stall      (rename_stall)
  );

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    instr_valid = 0; reg_write = 0; architectural_rd = 0;
    architectural_rs1 = 0; architectural_rs2 = 0;
    wakeup_active = 0; wakeup_tag = 0; wakeup_value = 0;
    free_valid = 0; free_tag = 0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    step();
    reset = 0;
    #1;
  endtask

  task automatic rename(input logic [4:0] rd, input logic wr,
                        input logic [4:0] rs1, input logic [4:0] rs2);
    instr_valid = 1; reg_write = wr; architectural_rd = rd;
    architectural_rs1 = rs1; architectural_rs2 = rs2;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    rename(5'd0, 1'b0, 5'd5, 5'd7);
    checks++;
    if (physical_rs1 !== 6'd5 || physical_rs2 !== 6'd7) begin
      failures++;
      $display("FAIL reset_map: prs1=%0d prs2=%0d expected 5 7", physical_rs1, physical_rs2);
    end
    checks++;
    if ({rs1_ready, rs2_ready} !== 2'b11 || rs1_value !== 32'd0 || rs2_value !== 32'd0) begin
      failures++;
      $display("FAIL reset_ready: rdy=%b%b v1=%h v2=%h expected 11 0 0",
               rs1_ready, rs2_ready, rs1_value, rs2_value);
    end
    checks++;
    if (physical_rd !== 6'd0 || old_physical_rd !== 6'd0 || rename_stall !== 1'b0) begin
      failures++;
      $display("FAIL reset_rd: prd=%0d old=%0d stall=%b expected 0 0 0",
               physical_rd, old_physical_rd, rename_stall);
    end
  endtask

  task automatic test_alloc();
    rename(5'd3, 1'b1, 5'd3, 5'd4);
    checks++;
    if (physical_rd !== 6'd32 || old_physical_rd !== 6'd3 || physical_rs1 !== 6'd3
        || rs1_ready !== 1'b1) begin
      failures++;
      $display("FAIL alloc_first: prd=%0d old=%0d prs1=%0d rdy1=%b expected 32 3 3 1",
               physical_rd, old_physical_rd, physical_rs1, rs1_ready);
    end
    step();
    rename(5'd0, 1'b0, 5'd3, 5'd4);
    checks++;
    if (physical_rs1 !== 6'd32 || rs1_ready !== 1'b0 || physical_rs2 !== 6'd4) begin
      failures++;
      $display("FAIL alloc_remap: prs1=%0d rdy1=%b prs2=%0d expected 32 0 4",
               physical_rs1, rs1_ready, physical_rs2);
    end
  endtask

  task automatic test_wakeup();
    wakeup_active = 1; wakeup_tag = 6'd32; wakeup_value = 32'hDEADBEEF;
    rename(5'd0, 1'b0, 5'd3, 5'd0);
`ifdef RENAME_BYPASS_EN
    checks++;
    if (rs1_ready !== 1'b1 || rs1_value !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL wakeup_bypass: rdy1=%b v1=%h expected 1 deadbeef", rs1_ready, rs1_value);
    end
`else
    checks++;
    if (rs1_ready !== 1'b0) begin
      failures++;
      $display("FAIL wakeup_early: rdy1=%b expected 0 before edge", rs1_ready);
    end
`endif
    step();
    wakeup_active = 0;
    rename(5'd0, 1'b0, 5'd3, 5'd0);
    checks++;
    if (physical_rs1 !== 6'd32 || rs1_ready !== 1'b1 || rs1_value !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL wakeup_read: prs1=%0d rdy1=%b v1=%h expected 32 1 deadbeef",
               physical_rs1, rs1_ready, rs1_value);
    end
  endtask

  task automatic test_exhaust();
    int bad = 0;
    do_reset();
    // A push into a full free list must be dropped.
    free_valid = 1; free_tag = 6'd9;
    step();
    free_valid = 0;
    for (int i = 0; i < 32; i++) begin
      rename(5'((i % 31) + 1), 1'b1, 5'd0, 5'd0);
      if (physical_rd !== 6'(32 + i) || rename_stall !== 1'b0) begin
        bad++;
        $display("FAIL exhaust_seq: alloc %0d prd=%0d stall=%b expected %0d 0",
                 i, physical_rd, rename_stall, 32 + i);
      end
      step();
    end
    checks++;
    if (bad != 0) failures++;
    rename(5'd10, 1'b1, 5'd0, 5'd0);
    checks++;
    if (rename_stall !== 1'b1 || physical_rd !== 6'd0 || old_physical_rd !== 6'd0) begin
      failures++;
      $display("FAIL exhaust_stall: stall=%b prd=%0d old=%0d expected 1 0 0",
               rename_stall, physical_rd, old_physical_rd);
    end
    step();
    rename(5'd0, 1'b0, 5'd10, 5'd1);
    checks++;
    if (physical_rs1 !== 6'd41 || physical_rs2 !== 6'd63) begin
      failures++;
      $display("FAIL exhaust_rat: prs1=%0d prs2=%0d expected 41 63", physical_rs1, physical_rs2);
    end
    instr_valid = 0;
    free_valid = 1; free_tag = 6'd5;
    step();
    free_valid = 0;
    // Allocation of the freed tag while a wakeup targets it: allocation wins.
    wakeup_active = 1; wakeup_tag = 6'd5; wakeup_value = 32'h1234;
    rename(5'd2, 1'b1, 5'd0, 5'd0);
    checks++;
    if (physical_rd !== 6'd5 || old_physical_rd !== 6'd33 || rename_stall !== 1'b0) begin
      failures++;
      $display("FAIL exhaust_refill: prd=%0d old=%0d stall=%b expected 5 33 0",
               physical_rd, old_physical_rd, rename_stall);
    end
    step();
    wakeup_active = 0;
    rename(5'd0, 1'b0, 5'd2, 5'd0);
    checks++;
    if (physical_rs1 !== 6'd5 || rs1_ready !== 1'b0) begin
      failures++;
      $display("FAIL alloc_vs_wakeup: prs1=%0d rdy1=%b expected 5 0", physical_rs1, rs1_ready);
    end
  endtask

  task automatic test_x0();
    do_reset();
    rename(5'd0, 1'b1, 5'd0, 5'd0);
    checks++;
    if (physical_rd !== 6'd0 || old_physical_rd !== 6'd0 || rename_stall !== 1'b0) begin
      failures++;
      $display("FAIL x0_noalloc: prd=%0d old=%0d stall=%b expected 0 0 0",
               physical_rd, old_physical_rd, rename_stall);
    end
    checks++;
    if (physical_rs1 !== 6'd0 || rs1_ready !== 1'b1 || rs1_value !== 32'd0) begin
      failures++;
      $display("FAIL x0_read: prs1=%0d rdy1=%b v1=%h expected 0 1 0",
               physical_rs1, rs1_ready, rs1_value);
    end
    step();
    rename(5'd1, 1'b1, 5'd0, 5'd0);
    checks++;
    if (physical_rd !== 6'd32) begin
      failures++;
      $display("FAIL x0_head: prd=%0d expected 32", physical_rd);
    end
    step();
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 31; i++) begin
      rename(5'd1, 1'b1, 5'd0, 5'd0);
      step();
    end
    // One tag left: pop 63 and push 7 together, count stays at one.
    free_valid = 1; free_tag = 6'd7;
    rename(5'd2, 1'b1, 5'd0, 5'd0);
    checks++;
    if (physical_rd !== 6'd63) begin
      failures++;
      $display("FAIL b2b_last: prd=%0d expected 63", physical_rd);
    end
    step();
    free_valid = 0;
    rename(5'd3, 1'b1, 5'd0, 5'd0);
    checks++;
    if (physical_rd !== 6'd7 || rename_stall !== 1'b0) begin
      failures++;
      $display("FAIL b2b_wrap: prd=%0d stall=%b expected 7 0", physical_rd, rename_stall);
    end
    step();
    rename(5'd4, 1'b1, 5'd0, 5'd0);
    checks++;
    if (rename_stall !== 1'b1) begin
      failures++;
      $display("FAIL b2b_empty: stall=%b expected 1", rename_stall);
    end
    // Reset mid-sequence restores the identity map and a full free list.
    reset = 1;
    step();
    reset = 0;
    rename(5'd4, 1'b1, 5'd3, 5'd1);
    checks++;
    if (physical_rs1 !== 6'd3 || physical_rs2 !== 6'd1 || physical_rd !== 6'd32
        || old_physical_rd !== 6'd4 || rename_stall !== 1'b0) begin
      failures++;
      $display("FAIL b2b_reset: prs1=%0d prs2=%0d prd=%0d old=%0d stall=%b expected 3 1 32 4 0",
               physical_rs1, physical_rs2, physical_rd, old_physical_rd, rename_stall);
    end
    step();
    idle();
  endtask

  initial begin
    reset = 1;
    idle();
    test_reset();
    test_alloc();
    test_wakeup();
    test_exhaust();
    test_x0();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rename_stage.md
Name: rename_stage

Overview:
- Register-rename stage of the out-of-order front end; sits between decode and issue.
- Maps 5-bit architectural registers to 6-bit physical tags through a register alias table (RAT) and a free list of physical tags.
- Holds a physical register file with a ready bit per tag. Wakeup broadcasts from execute update this file.
- Returns each source's tag, ready bit and value, and allocates a fresh tag for the destination.

Parameters:
- NUM_ARCH, 32, number of architectural registers; x0 is hard-wired to zero.
- NUM_PHYS, 64, number of physical registers; tag width TAG_W = clog2(NUM_PHYS) = 6.
- DATA_W, 32, register value width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- instr_valid  in  1  a decoded instruction is presented this cycle.
- reg_write  in  1  the instruction writes rd.
- architectural_rd  in  5  destination architectural register.
- architectural_rs1  in  5  source 1 architectural register.
- architectural_rs2  in  5  source 2 architectural register.
- wakeup_active  in  1  result broadcast valid.
- wakeup_tag  in  6  physical tag being completed.
- wakeup_value  in  32  result value for wakeup_tag.
- free_valid  in  1  retirement returns a tag to the free list.
- free_tag  in  6  tag being returned.
- physical_rd  out  6  newly allocated tag; 0 when no allocation occurs.
- old_physical_rd  out  6  previous mapping of rd, passed to the ROB for later freeing.
- physical_rs1  out  6  current mapping of rs1.
- physical_rs2  out  6  current mapping of rs2.
- rs1_ready  out  1  rs1 value available.
- rs2_ready  out  1  rs2 value available.
- rs1_value  out  32  rs1 value; meaningful only when rs1_ready is 1.
- rs2_value  out  32  rs2 value; meaningful only when rs2_ready is 1.
- rename_stall  out  1  free list empty; upstream must hold the instruction.

Behaviour:
- Reset (synchronous):
  - RAT[i] = i for i in 0..31.
  - Tags 0..31: ready=1, value=0.
  - Tags 32..63: ready=0, value=0.
  - Free list is a FIFO holding 32..63, in order, head=32; count=32.
  - All outputs are combinational from this state. After reset: physical_rsN = architectural_rsN, rsN_ready=1, rsN_value=0, physical_rd=0, rename_stall=0.
- Lookups are combinational in the same cycle: physical_rsN = RAT[architectural_rsN]; ready and value come from the physical file at that tag.
- Sources always read the pre-update RAT, so an instruction whose rd equals one of its rs sees the old mapping.
- Allocation occurs when instr_valid & reg_write & architectural_rd != 0 & free list not empty. Then:
  - physical_rd = free-list head, combinationally.
  - old_physical_rd = RAT[rd].
  - At posedge: RAT[rd] <= head, pop the free list, ready[head] <= 0.
- When no allocation occurs, physical_rd = 0 and old_physical_rd = 0. Writes to x0 never allocate; RAT[0] stays 0 permanently.
- rename_stall = instr_valid & reg_write & rd != 0 & count == 0. While stalled, no state changes; a simultaneous free or wakeup still applies.
- Wakeup: if wakeup_active and wakeup_tag != 0, at posedge value[tag] <= wakeup_value and ready[tag] <= 1.
- If allocation and wakeup target the same tag in one cycle, allocation wins: ready=0.
- Free: if free_valid and free_tag >= 32... more precisely any free_tag != 0, push it at the tail at posedge.
  - Simultaneous pop and push are both applied; count is unchanged.
  - A push when count == NUM_PHYS-NUM_ARCH (full) is ignored.
- Free-list head and tail pointers wrap modulo 32.
- Tag 0 is always ready with value 0.

Optional Feature:
- RENAME_BYPASS_EN defined: if wakeup_active and wakeup_tag == physical_rsN (nonzero), rsN_ready=1 and rsN_value=wakeup_value in the same cycle.
- Not defined: the wakeup becomes visible on the cycle after the posedge.

Decomposition:
- Package rename_pkg holds NUM_ARCH, NUM_PHYS, DATA_W, TAG_W and typedefs tag_t, areg_t, data_t.
- One sub-module, rename_free_list: circular FIFO of tags with push, pop, count, empty and full, reset-initialised to 32..63.
- RAT and physical file stay in rename_stage.

Test Plan:
- Reset, then rs1=5, rs2=7, no rd write -> physical_rs1=5, physical_rs2=7, both ready, values 0, physical_rd=0.
- Write rd=3 (add x3,x3,x4) -> physical_rd=32, old_physical_rd=3, physical_rs1=3; next cycle rs1=3 -> tag 32, ready=0.
- wakeup_active, tag=32, value=0xDEADBEEF, then read x3 -> tag 32, ready=1, value 0xDEADBEEF. With RENAME_BYPASS_EN, also correct in the same cycle.
- 32 consecutive allocations -> tags 32..63. On the 33rd: rename_stall=1, physical_rd=0, RAT unchanged. Then free_tag=5 -> next allocation gets tag 5.
- rd=0 with reg_write=1 -> no allocation, free count unchanged, rs reading x0 -> tag 0, ready, value 0.
- Allocate and free in the same cycle -> count unchanged; reset mid-sequence -> identity map and full free list on the next cycle.
